// File: rtl/uart_rx_frame_if.sv
// Receive-side valid/ready handshake for uart_rx_frame.
// The master drives the received word and its status; the slave (FIFO or
// register block) returns rx_ready.
interface uart_rx_frame_if #(
    parameter int DATA_MAX = 9
);
    logic [DATA_MAX-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [1:0]          rx_status;   // {parity_err, framing_err}

    modport master (
        output rx_data,
        output rx_valid,
        output rx_status,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_status,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with majority filter, 5..9 data
// bits, optional parity and 1 or 2 stop bits. Each frame is presented with
// its error status on a valid/ready interface.
//
// Optional build macro UART_RX_BREAK_EN: adds a break_det pulse output and
// swallows break frames (all-zero data with a framing error) instead of
// delivering them.
module uart_rx_frame #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_MAX    = 9,
    parameter int FILTER_TAPS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   baud_tick,
    input  logic                   rx,
    input  logic [3:0]             cfg_data_bits,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_odd,
    input  logic                   cfg_stop2,
    uart_rx_frame_if.master        rx_if,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic                   rx_idle
`ifdef UART_RX_BREAK_EN
    ,
    output logic                   break_det
`endif
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Receive state machine and sampling
    state_t                 state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [FILTER_TAPS-1:0] taps_q, taps_d;
    logic [2:0]             ones;
    logic                   rx_f;

    // Per-frame configuration shadow
    logic [3:0]             nbits_q, nbits_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   stop2_q, stop2_d;
    logic [3:0]             cfg_bits_norm;

    // Frame assembly
    logic [DATA_MAX-1:0]    shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   done_q, done_d;
    // Set once the filtered line has been seen high in IDLE; a break leaves
    // it clear so a held-low line cannot retrigger a start.
    logic                   armed_q, armed_d;

    // Output holding stage
    logic [DATA_MAX-1:0]    data_q, data_d;
    logic [1:0]             status_q, status_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   is_break, push, ovf_set;
`ifdef UART_RX_BREAK_EN
    logic                   break_q, break_d;
`endif

    // Majority filter over the last FILTER_TAPS oversamples of rx
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        ones = '0;
        for (int i = 0; i < FILTER_TAPS; i++) begin
            ones = ones + {2'b00, taps_q[i]};
        end
        rx_f   = (ones > 3'(FILTER_TAPS / 2));
        taps_d = baud_tick ? ((taps_q << 1) | FILTER_TAPS'(rx)) : taps_q;
    end

    // Out-of-range data lengths fall back to 8 bits
    always_comb begin
        cfg_bits_norm = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd9))
                      ? cfg_data_bits : 4'd8;
    end

    // Next-state and frame datapath; everything advances on baud_tick only
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bitcnt_d  = bitcnt_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        armed_d   = armed_q;
        done_d    = 1'b0;

        if (baud_tick) begin
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);

            case (state_q)
                S_IDLE: begin
                    if (rx_f) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d   = S_START;
                        nbits_d   = cfg_bits_norm;
                        par_en_d  = cfg_parity_en;
                        par_odd_d = cfg_parity_odd;
                        stop2_d   = cfg_stop2;
                    end
                end

                S_START: begin
                    if (tcnt_q == T_MID) begin
                        if (!rx_f) begin
                            // Frame is real: clear the assembly registers here
                            // so a completion still being unloaded is untouched.
                            state_d   = S_DATA;
                            shift_d   = '0;
                            bitcnt_d  = '0;
                            par_acc_d = 1'b0;
                            perr_d    = 1'b0;
                            ferr_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (tcnt_q == T_LAST) begin
                        for (int i = 0; i < DATA_MAX; i++) begin
                            if (bitcnt_q == 4'(i)) begin
                                shift_d[i] = rx_f;
                            end
                        end
                        par_acc_d = par_acc_q ^ rx_f;
                        bitcnt_d  = bitcnt_q + 4'd1;
                        if (bitcnt_q == nbits_q - 4'd1) begin
                            state_d = par_en_q ? S_PARITY : S_STOP1;
                        end
                    end
                end

                S_PARITY: begin
                    if (tcnt_q == T_LAST) begin
                        perr_d  = ((par_acc_q ^ rx_f) != par_odd_q);
                        state_d = S_STOP1;
                    end
                end

                S_STOP1: begin
                    if (tcnt_q == T_LAST) begin
                        ferr_d = ~rx_f;
                        if (stop2_q) begin
                            state_d = S_STOP2;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            if (!rx_f) armed_d = 1'b0;
                        end
                    end
                end

                S_STOP2: begin
                    if (tcnt_q == T_LAST) begin
                        ferr_d  = ferr_q | ~rx_f;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (ferr_q || !rx_f) armed_d = 1'b0;
                    end
                end

                default: state_d = S_IDLE;
            endcase

            if (state_d != state_q) begin
                tcnt_d = '0;
            end
        end
    end

    // Output stage: deliver completed frames, handle handshake and overflow
    always_comb begin
`ifdef UART_RX_BREAK_EN
        is_break = done_q && (shift_q == '0) && ferr_q;
        break_d  = is_break;
`else
        is_break = 1'b0;
`endif
        push     = done_q && !is_break;
        valid_d  = valid_q;
        data_d   = data_q;
        status_d = status_q;
        ovf_set  = 1'b0;

        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end
        if (push) begin
            if (!valid_q || rx_if.rx_ready) begin
                valid_d  = 1'b1;
                data_d   = shift_q;
                status_d = {perr_q, ferr_q};
            end else begin
                ovf_set = 1'b1;
            end
        end

        overflow_d = clear_overflow ? 1'b0 : (overflow_q | ovf_set);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            bitcnt_q   <= '0;
            taps_q     <= '1;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            data_q     <= '0;
            status_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bitcnt_q   <= bitcnt_d;
            taps_q     <= taps_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            status_q   <= status_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
`ifdef UART_RX_BREAK_EN
            break_q    <= break_d;
`endif
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_status = status_q;
    assign rx_if.rx_valid  = valid_q;
    assign overflow        = overflow_q;
    assign rx_idle         = (state_q == S_IDLE);
`ifdef UART_RX_BREAK_EN
    assign break_det       = break_q;
`endif

endmodule
